sw_debounce: RTL
================

Name: sw_debounce

Overview:
- Conditions the raw BE-MICRO MAX10 slide switches before they reach the Nios sw PIO input (sw_export).
- Processes each bit independently:
  - 2-flop synchroniser into CLK_50.
  - Saturating stability counter.
  - Debounced level output.
  - One-cycle rise/fall pulses.
  - Sticky per-bit change flags with software clear.
- Sits between the SW pins and the Nios system in the board top level.

Parameters:
- WIDTH, 4: number of switch bits handled.
- DB_CYCLES, 500000: consecutive stable CLK_50 cycles required to accept a new level (10 ms at 50 MHz). Legal range is 2 to 2^24; the bench uses 8.
- CNT_W, 24: stability counter width. Must satisfy 2^CNT_W >= DB_CYCLES.

Ports:
- CLK_50  input  1  system clock, 50 MHz, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- SW_IN  input  WIDTH  raw asynchronous switch pins.
- SW_OUT  output  WIDTH  debounced switch levels, drives sw_export.
- SW_RISE  output  WIDTH  one-cycle pulse when SW_OUT[i] goes 0->1.
- SW_FALL  output  WIDTH  one-cycle pulse when SW_OUT[i] goes 1->0.
- SW_CHANGED  output  WIDTH  sticky flag, set on any SW_OUT[i] transition.
- CHG_CLR  input  WIDTH  per-bit clear strobe for SW_CHANGED.

Behaviour:
- Interface: one clock, CLK_50; reset is synchronous and active-high (RESET). No other clock or reset.
- Reset (RESET=1 at a rising edge): the following all go to 0:
  - sync flops, counters, SW_OUT, SW_RISE, SW_FALL, SW_CHANGED.
- Reset asserted mid-count discards the partial count. After reset, the first accepted level starts from SW_OUT=0.
- Synchroniser: s1 <= SW_IN; s2 <= s1. No logic between the two flops.
- Per bit i, at each edge (RESET=0):
  - s2[i] == SW_OUT[i]: cnt[i] <= 0.
  - s2[i] != SW_OUT[i] and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != SW_OUT[i] and cnt[i] == DB_CYCLES-1: SW_OUT[i] <= s2[i]; cnt[i] <= 0; pulse generated.
- Latency: a clean input change seen at edge k (captured in s1) appears on SW_OUT at edge k+1+DB_CYCLES.
- Glitch rejection: any glitch shorter than DB_CYCLES cycles, measured at s2, is fully rejected. Any return of s2 to the current SW_OUT level restarts the count from 0. Counters never wrap.
- Pulses: SW_RISE[i] / SW_FALL[i] are registered and high for exactly the one cycle in which SW_OUT[i] first shows the new level. Both are 0 in every other cycle. Rise and fall are never high together for the same bit.
- Sticky flag:
  - SW_CHANGED[i] <= (SW_CHANGED[i] & ~CHG_CLR[i]) | SW_RISE_next[i] | SW_FALL_next[i].
  - It sets in the same cycle as the pulse.
  - If a clear and a new transition coincide, set wins.
  - CHG_CLR on a bit with no flag set has no effect.
- Power-up case: a switch held at 1 through reset produces one SW_RISE pulse and sets SW_CHANGED at edge 2+DB_CYCLES after reset release. This is required; firmware relies on it to read the initial state.
- Bits are fully independent. Simultaneous transitions on several bits yield simultaneous pulses.
- Purely synchronous design: no latches, no combinational path from any input to any output.

Test Plan (DB_CYCLES=8):
- Reset then SW_IN=4'b0000 held 50 cycles -> SW_OUT, SW_RISE, SW_FALL and SW_CHANGED stay 0 throughout.
- SW_IN[0] 0->1 clean at edge k -> SW_OUT[0]=1 and SW_RISE[0]=1 for exactly one cycle at edge k+9. SW_CHANGED[0]=1 from then on. Other bits stay unchanged.
- SW_IN[1] bounce pattern 1,0,1,1,0,1 (one cycle each), then held 1 -> no output until 8 stable cycles at s2. A single SW_RISE[1] pulse follows; no SW_FALL[1] pulse.
- SW_IN[2] glitch high for 7 cycles, then low -> SW_OUT[2] stays 0 and no pulse occurs. An 8-cycle high glitch -> accepted, followed by a matching fall 9 edges after the input drops.
- CHG_CLR[0] pulsed in the same cycle as a new SW_FALL[0] -> SW_CHANGED[0] remains 1. CHG_CLR[0] pulsed alone afterwards -> SW_CHANGED[0] = 0 next cycle.
- SW_IN=4'b1111 held, RESET asserted at count 5, then released -> all outputs 0 during reset. SW_RISE=4'b1111 one-cycle pulse and SW_OUT=4'b1111 both occur 10 edges after release.

Source files
------------

// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus between the board pins/firmware side and the debouncer.
// The master side drives the raw pins and the clear strobes. The slave side,
// which is the debouncer, returns the conditioned levels, the pulses and the flags.
interface sw_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] SW_IN;
  logic [WIDTH-1:0] CHG_CLR;
  logic [WIDTH-1:0] SW_OUT;
  logic [WIDTH-1:0] SW_RISE;
  logic [WIDTH-1:0] SW_FALL;
  logic [WIDTH-1:0] SW_CHANGED;

  modport master (
    output SW_IN,
    output CHG_CLR,
    input  SW_OUT,
    input  SW_RISE,
    input  SW_FALL,
    input  SW_CHANGED
  );

  modport slave (
    input  SW_IN,
    input  CHG_CLR,
    output SW_OUT,
    output SW_RISE,
    output SW_FALL,
    output SW_CHANGED
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit slide-switch debouncer. The raw pins pass through a 2-flop
// synchroniser. A saturating stability counter then accepts a new level only
// after DB_CYCLES consecutive cycles of disagreement with the current level.
// Each accepted change produces a one-cycle rise or fall pulse and sets a
// sticky change flag, which firmware clears per bit.
module sw_debounce #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 24
) (
  input logic         CLK_50,
  input logic         RESET,
  sw_debounce_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] accept;

  // Bits whose synchronised level has disagreed for long enough to be taken this edge
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (s2[i] != out_q[i]) && (cnt[i] == LAST);
    end
  end

  // Synchroniser, stability counters, debounced level, pulses and sticky flags
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      s1     <= '0;
      s2     <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= bus.SW_IN;
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == out_q[i]) begin
          // Agreement with the current level restarts the stability count.
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
        if (accept[i]) begin
          out_q[i] <= s2[i];
        end
      end
      rise_q <= accept & s2;
      fall_q <= accept & ~s2;
      // A new transition wins over a coincident clear.
      chg_q  <= (chg_q & ~bus.CHG_CLR) | accept;
    end
  end

  assign bus.SW_OUT     = out_q;
  assign bus.SW_RISE    = rise_q;
  assign bus.SW_FALL    = fall_q;
  assign bus.SW_CHANGED = chg_q;
endmodule
